// File: rtl/hsv_core_pkg.sv
// Shared core definitions used by the data-memory AXI-Lite responder.
//   AXI_RESP_*          : 2-bit AXI response codes (only OKAY and DECERR are ever produced)
//   dmem_slave_state_t  : states of the dmem responder FSM
package hsv_core_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_RD_ACCESS,
    DS_RD_RESP,
    DS_WR_COLLECT,
    DS_WR_ACCESS,
    DS_WR_RESP
  } dmem_slave_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle between the core memory unit (m) and a memory responder (s).
// 32-bit address and data, 4-bit write strobe, 2-bit responses.
//
// Handshake rule for every channel: a transfer happens on the rising clk_core
// edge where valid and ready are both high; once valid is raised the payload
// holds stable until that edge.
interface axil_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport m (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport s (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/hsv_dmem_sram.sv
// Single-port synchronous word RAM with byte enables.
//   clk_core : clock
//   en       : access enable (read when we=0, write when we=1)
//   we       : write enable
//   be       : byte enables for writes
//   addr     : word index
//   wdata    : write data
//   rdata    : read data, valid the cycle after an enabled read; holds otherwise
// Contents are not reset.
module hsv_dmem_sram #(
  parameter int unsigned DEPTH = 4096
) (
  input  logic                       clk_core,
  input  logic                       en,
  input  logic                       we,
  input  logic [3:0]                 be,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk_core) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/hsv_dmem_axil_slave.sv
// AXI-Lite responder serving the core's data-memory port from on-chip SRAM.
// One transaction in flight at a time; out-of-window accesses answer DECERR
// with no side effects.
//   DEPTH_WORDS : SRAM size in 32-bit words (power of two, >= 2)
//   BASE_ADDR   : byte address of word 0 (aligned to DEPTH_WORDS*4)
//   clk_core    : core clock
//   rst_core_n  : asynchronous active-low reset
//   dmem        : AXI-Lite slave modport
// The FSM state is held in `state` (dmem_slave_state_t) for checker binding.
module hsv_dmem_axil_slave
  import hsv_core_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic clk_core,
  input  logic rst_core_n,
  axil_if.s    dmem
);

  localparam int unsigned IDX_W        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH_WORDS * 4);

  dmem_slave_state_t state, state_nx;

  logic        last_was_write;
  logic [31:0] ar_addr_q, aw_addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        aw_held, w_held;
  logic [1:0]  rresp_q, bresp_q;
  logic        rvalid_q, bvalid_q;

  logic        arready, awready, wready;
  logic        ar_hs, aw_hs, w_hs, r_hs, b_hs;
  logic        tie;

  logic [31:0] acc_addr, acc_off;
  logic        acc_in_range;
  logic [31:0] sram_rdata;

  // A tie is a read request competing with any part of a write request.
  assign tie = dmem.arvalid && (dmem.awvalid || dmem.wvalid);

  // Readies are forced low while reset is asserted so nothing is accepted.
  always_comb begin
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    if (rst_core_n) begin
      case (state)
        DS_IDLE: begin
          // Round robin: whichever kind completed last loses a tie.
          arready = !(tie && !last_was_write);
          awready = !(tie && last_was_write);
          wready  = !(tie && last_was_write);
        end
        DS_WR_COLLECT: begin
          awready = !aw_held;
          wready  = !w_held;
        end
        default: ;
      endcase
    end
  end

  assign ar_hs = dmem.arvalid && arready;
  assign aw_hs = dmem.awvalid && awready;
  assign w_hs  = dmem.wvalid  && wready;
  assign r_hs  = rvalid_q && dmem.rready;
  assign b_hs  = bvalid_q && dmem.bready;

  // Decode is shared by both access states; low address bits drop out of the index.
  assign acc_addr     = (state == DS_RD_ACCESS) ? ar_addr_q : aw_addr_q;
  assign acc_off      = acc_addr - BASE_ADDR;
  assign acc_in_range = acc_off < WINDOW_BYTES;

  hsv_dmem_sram #(.DEPTH(DEPTH_WORDS)) u_sram (
    .clk_core (clk_core),
    .en       (((state == DS_RD_ACCESS) || (state == DS_WR_ACCESS)) && acc_in_range),
    .we       (state == DS_WR_ACCESS),
    .be       (wstrb_q),
    .addr     (IDX_W'(acc_off >> 2)),
    .wdata    (wdata_q),
    .rdata    (sram_rdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      DS_IDLE: begin
        if (ar_hs)               state_nx = DS_RD_ACCESS;
        else if (aw_hs && w_hs)  state_nx = DS_WR_ACCESS;
        else if (aw_hs || w_hs)  state_nx = DS_WR_COLLECT;
      end
      DS_RD_ACCESS:  state_nx = DS_RD_RESP;
      DS_RD_RESP:    if (r_hs) state_nx = DS_IDLE;
      DS_WR_COLLECT: if ((aw_held || aw_hs) && (w_held || w_hs)) state_nx = DS_WR_ACCESS;
      DS_WR_ACCESS:  state_nx = DS_WR_RESP;
      DS_WR_RESP:    if (b_hs) state_nx = DS_IDLE;
      default:       state_nx = DS_IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state          <= DS_IDLE;
      last_was_write <= 1'b1;
      ar_addr_q      <= '0;
      aw_addr_q      <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      rresp_q        <= AXI_RESP_OKAY;
      bresp_q        <= AXI_RESP_OKAY;
      rvalid_q       <= 1'b0;
      bvalid_q       <= 1'b0;
    end else begin
      state <= state_nx;
      if (ar_hs) ar_addr_q <= dmem.araddr;
      if (aw_hs) begin
        aw_addr_q <= dmem.awaddr;
        aw_held   <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= dmem.wdata;
        wstrb_q <= dmem.wstrb;
        w_held  <= 1'b1;
      end
      if (state == DS_RD_ACCESS) rresp_q <= acc_in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
      if (state == DS_WR_ACCESS) begin
        bresp_q <= acc_in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      rvalid_q <= (state_nx == DS_RD_RESP);
      bvalid_q <= (state_nx == DS_WR_RESP);
      if (r_hs) last_was_write <= 1'b0;
      if (b_hs) last_was_write <= 1'b1;
    end
  end

  assign dmem.arready = arready;
  assign dmem.awready = awready;
  assign dmem.wready  = wready;
  assign dmem.rvalid  = rvalid_q;
  assign dmem.rresp   = rresp_q;
  // The SRAM output holds while not enabled, so rdata stays stable during a stall.
  assign dmem.rdata   = (rvalid_q && (rresp_q == AXI_RESP_OKAY)) ? sram_rdata : 32'h0;
  assign dmem.bvalid  = bvalid_q;
  assign dmem.bresp   = bresp_q;

endmodule

// File: tb/tb_hsv_dmem_axil_slave.sv
// Testbench for hsv_dmem_axil_slave: directed scenarios followed by random
// traffic, with a queue of expected responses consumed by a response monitor.
// Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge.
module tb_hsv_dmem_axil_slave;
  import hsv_core_pkg::*;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          W     = 35; // {is_write, resp[1:0], data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk_core   = 1'b0;
  logic rst_core_n = 1'b0;
  int   cyc        = 0;

  always #5 clk_core = ~clk_core;
  always @(posedge clk_core) cyc <= cyc + 1;

  axil_if dmem ();

  hsv_dmem_axil_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .dmem       (dmem)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [31:0]  model_mem [DEPTH];
  bit           known     [DEPTH];
  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic bit in_win(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off / 4);
  endfunction

  task automatic push_read(input logic [31:0] a);
    if (in_win(a)) exp_q.push_back({1'b0, AXI_RESP_OKAY, model_mem[word_of(a)]});
    else           exp_q.push_back({1'b0, AXI_RESP_DECERR, 32'h0});
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    logic [31:0] v;
    if (in_win(a)) begin
      i = word_of(a);
      v = model_mem[i];
      for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
      model_mem[i] = v;
      if (s == 4'hF) known[i] = 1'b1;
      exp_q.push_back({1'b1, AXI_RESP_OKAY, 32'h0});
    end else begin
      exp_q.push_back({1'b1, AXI_RESP_DECERR, 32'h0});
    end
  endtask

  // ---------------- response monitor ----------------
  bit          r_stall = 1'b0, b_stall = 1'b0;
  logic [31:0] r_prev_data;
  logic [1:0]  r_prev_resp, b_prev_resp;

  always @(negedge clk_core) begin
    logic [W-1:0] e;
    if (!rst_core_n) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (dmem.rvalid) begin
        if (r_stall) begin
          check("rdata_stable", dmem.rdata, r_prev_data);
          check("rresp_stable", 32'(dmem.rresp), 32'(r_prev_resp));
        end
        if (dmem.rready) begin
          if (exp_q.size() == 0) fail_now("r_unexpected");
          else begin
            e = exp_q.pop_front();
            check("resp_order_r", 32'(0), 32'(e[34]));
            check("rresp", 32'(dmem.rresp), 32'(e[33:32]));
            check("rdata", dmem.rdata, e[31:0]);
          end
          r_stall = 1'b0;
        end else begin
          r_stall     = 1'b1;
          r_prev_data = dmem.rdata;
          r_prev_resp = dmem.rresp;
        end
      end else r_stall = 1'b0;

      if (dmem.bvalid) begin
        if (b_stall) check("bresp_stable", 32'(dmem.bresp), 32'(b_prev_resp));
        if (dmem.bready) begin
          if (exp_q.size() == 0) fail_now("b_unexpected");
          else begin
            e = exp_q.pop_front();
            check("resp_order_b", 32'(1), 32'(e[34]));
            check("bresp", 32'(dmem.bresp), 32'(e[33:32]));
          end
          b_stall = 1'b0;
        end else begin
          b_stall     = 1'b1;
          b_prev_resp = dmem.bresp;
        end
      end else b_stall = 1'b0;
    end
  end

  always @(posedge clk_core) begin
    #2;
    if (rand_ready) begin
      dmem.rready = ($urandom_range(0, 3) != 0);
      dmem.bready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks (start and end 2 ns after a rising edge) ----------------
  task automatic drive_read(input logic [31:0] a, input bit chk_lat);
    bit hs = 1'b0;
    dmem.araddr  = a;
    dmem.arvalid = 1'b1;
    for (int n = 0; n < 200 && !hs; n++) begin
      @(negedge clk_core);
      hs = dmem.arready;
      @(posedge clk_core);
      #2;
    end
    dmem.arvalid = 1'b0;
    if (!hs) fail_now("ar_timeout");
    else if (chk_lat) begin
      @(negedge clk_core);
      check("rvalid_lat_n+1", 32'(dmem.rvalid), 32'(0));
      @(negedge clk_core);
      check("rvalid_lat_n+2", 32'(dmem.rvalid), 32'(1));
      @(posedge clk_core);
      #2;
    end
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input bit chk_lat);
    bit aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
    int k = 0;
    dmem.awaddr = a;
    dmem.wdata  = d;
    dmem.wstrb  = s;
    while (!(aw_done && w_done) && k < 200) begin
      dmem.awvalid = !aw_done && (k >= aw_dly);
      dmem.wvalid  = !w_done && (k >= w_dly);
      @(negedge clk_core);
      aw_hs = dmem.awvalid && dmem.awready;
      w_hs  = dmem.wvalid && dmem.wready;
      if (w_done && !aw_done) begin
        check("wready_low_when_held", 32'(dmem.wready), 32'(0));
        check("arready_low_partial_w", 32'(dmem.arready), 32'(0));
      end
      if (aw_done && !w_done) begin
        check("awready_low_when_held", 32'(dmem.awready), 32'(0));
        check("arready_low_partial_aw", 32'(dmem.arready), 32'(0));
      end
      @(posedge clk_core);
      #2;
      aw_done = aw_done || aw_hs;
      w_done  = w_done || w_hs;
      k++;
    end
    dmem.awvalid = 1'b0;
    dmem.wvalid  = 1'b0;
    if (!(aw_done && w_done)) fail_now("aw_w_timeout");
    else if (chk_lat) begin
      @(negedge clk_core);
      check("bvalid_lat_n+1", 32'(dmem.bvalid), 32'(0));
      @(negedge clk_core);
      check("bvalid_lat_n+2", 32'(dmem.bvalid), 32'(1));
      @(posedge clk_core);
      #2;
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk_core);
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
    @(posedge clk_core);
    #2;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input bit chk_lat);
    push_write(a, d, s);
    drive_write(a, d, s, aw_dly, w_dly, chk_lat);
  endtask

  task automatic do_read(input logic [31:0] a, input bit chk_lat);
    push_read(a);
    drive_read(a, chk_lat);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    dmem.araddr = '0; dmem.arvalid = 1'b0; dmem.rready = 1'b1;
    dmem.awaddr = '0; dmem.awvalid = 1'b0; dmem.wdata = '0; dmem.wstrb = '0;
    dmem.wvalid = 1'b0; dmem.bready = 1'b1;

    // reset values
    repeat (3) @(posedge clk_core);
    #2;
    check("rst_arready", 32'(dmem.arready), 32'(0));
    check("rst_awready", 32'(dmem.awready), 32'(0));
    check("rst_wready",  32'(dmem.wready),  32'(0));
    check("rst_rvalid",  32'(dmem.rvalid),  32'(0));
    check("rst_bvalid",  32'(dmem.bvalid),  32'(0));
    check("rst_rdata",   dmem.rdata, 32'h0);
    check("rst_rresp",   32'(dmem.rresp), 32'(0));
    check("rst_bresp",   32'(dmem.bresp), 32'(0));
    rst_core_n = 1'b1;
    @(negedge clk_core);
    check("post_rst_arready", 32'(dmem.arready), 32'(1));
    check("post_rst_awready", 32'(dmem.awready), 32'(1));
    check("post_rst_wready",  32'(dmem.wready),  32'(1));
    @(posedge clk_core);
    #2;

    // full-word write then read
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 1);
    do_read(32'h10, 1);
    wait_drain();

    // byte-enabled merge -> AA22BB44
    do_write(32'h20, 32'h1122_3344, 4'hF, 0, 0, 0);
    do_write(32'h20, 32'hAA00_BB00, 4'b1010, 0, 0, 0);
    do_read(32'h20, 0);
    wait_drain();
    check("merge_model", model_mem[8], 32'hAA22_BB44);

    // W leads AW by 3 cycles; wstrb=0 is a no-op with OKAY
    do_write(32'h4, 32'hCAFE_0004, 4'hF, 3, 0, 1);
    do_read(32'h4, 0);
    do_write(32'h4, 32'hFFFF_FFFF, 4'h0, 0, 2, 0);
    do_read(32'h6, 0);
    wait_drain();

    // out-of-window accesses, including one that wraps below BASE
    do_write(32'h0, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
    do_write(32'(DEPTH * 4), 32'h5555_5555, 4'hF, 0, 0, 0);
    do_read(32'(DEPTH * 4), 0);
    do_read(32'hFFFF_FFFC, 0);
    do_read(32'h0, 0);
    wait_drain();

    // simultaneous read/write requests; previous completed kind is a write
    do_write(32'h8, 32'h0000_0008, 4'hF, 0, 0, 0);
    wait_drain();
    dmem.rready = 1'b0;
    push_read(32'h10);
    push_write(32'h30, 32'h3030_3030, 4'hF);
    push_read(32'h20);
    push_write(32'h34, 32'h3434_3434, 4'hF);
    fork
      begin
        drive_read(32'h10, 0);
        drive_read(32'h20, 0);
      end
      begin
        drive_write(32'h30, 32'h3030_3030, 4'hF, 0, 0, 0);
        drive_write(32'h34, 32'h3434_3434, 4'hF, 0, 0, 0);
      end
      begin
        for (int n = 0; n < 100 && !dmem.rvalid; n++) @(negedge clk_core);
        repeat (5) @(negedge clk_core);
        @(posedge clk_core);
        #2;
        dmem.rready = 1'b1;
      end
    join
    wait_drain();
    do_read(32'h30, 0);
    do_read(32'h34, 0);
    wait_drain();

    // reset during a stalled read response
    dmem.rready = 1'b0;
    do_read(32'h10, 0);
    for (int n = 0; n < 50 && !dmem.rvalid; n++) @(negedge clk_core);
    check("rvalid_before_reset", 32'(dmem.rvalid), 32'(1));
    @(posedge clk_core);
    #2;
    rst_core_n = 1'b0;
    #1;
    check("mid_rst_rvalid",  32'(dmem.rvalid),  32'(0));
    check("mid_rst_arready", 32'(dmem.arready), 32'(0));
    exp_q.delete();
    repeat (2) @(posedge clk_core);
    #2;
    rst_core_n  = 1'b1;
    dmem.rready = 1'b1;
    @(negedge clk_core);
    check("after_rst_arready", 32'(dmem.arready), 32'(1));
    @(posedge clk_core);
    #2;
    do_read(32'h10, 1);
    wait_drain();

    // random traffic with random backpressure
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      bit          oob;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      oob = ($urandom_range(0, 7) == 0);
      if (oob) a = 32'(DEPTH * 4) + $urandom_range(0, 4095);
      else     a = 32'($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(0, 3);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0 && (oob || known[word_of(a)])) begin
        do_read(a, 0);
      end else begin
        if (!oob && !known[word_of(a)]) s = 4'hF;
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk_core);
    #3;
    dmem.rready = 1'b1;
    dmem.bready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
